// File: rtl/usb_cmd_pkg.sv
// Shared constants and types for the USB command frame parser.
// A frame is AA 55 | cmd | lenH | lenL | payload[len] | checksum.
package usb_cmd_pkg;

    localparam logic [7:0] FRAME_HDR0 = 8'hAA;
    localparam logic [7:0] FRAME_HDR1 = 8'h55;

    localparam logic [7:0] CMD_I2C_CONFIG       = 8'h04;
    localparam logic [7:0] CMD_I2C_WRITE        = 8'h05;
    localparam logic [7:0] CMD_I2C_READ         = 8'h06;
    localparam logic [7:0] CMD_I2C_WRITE_NOADDR = 8'h12;
    localparam logic [7:0] CMD_I2C_READ_NOADDR  = 8'h13;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HDR2,
        ST_CMD,
        ST_LEN_H,
        ST_LEN_L,
        ST_PAYLOAD,
        ST_CKSUM,
        ST_ANNOUNCE,
        ST_DRAIN,
        ST_DONE
    } parser_state_t;

endpackage

// File: rtl/frame_payload_ram.sv
// Payload buffer: one write port, one read port with a registered read.
// No reset on the array or the read register so it maps onto block RAM.
module frame_payload_ram #(
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [7:0]        i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [7:0]        o_rd_data
);

    logic [7:0] r_mem [2**ADDR_W];
    logic [7:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/usb_cmd_frame_parser.sv
// Deframes the USB byte stream, verifies the checksum over a buffered payload,
// then announces the command and streams the payload to handlers (valid/ready).
module usb_cmd_frame_parser
    import usb_cmd_pkg::*;
#(
    parameter int MAX_PAYLOAD    = 128,
    parameter int TIMEOUT_CYCLES = 500000,
    parameter int ADDR_W         = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  usb_data_in,
    input  logic        usb_data_valid_in,
    output logic        cmd_start,
    output logic [7:0]  cmd_code,
    output logic [15:0] cmd_len,
    output logic [7:0]  cmd_data,
    output logic        cmd_data_valid,
    input  logic        cmd_data_ready,
    output logic        cmd_done,
    output logic        busy,
    output logic        err_checksum,
    output logic        err_length,
    output logic        err_timeout,
    output logic        err_overrun
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    parser_state_t     r_state, w_state_next;
    logic [7:0]        r_cmd_work, r_len_hi, r_sum, r_cmd_code;
    logic [15:0]       r_len_work, r_cmd_len;
    logic [ADDR_W-1:0] r_wr_idx, r_rd_idx;
    logic [TMO_W-1:0]  r_tmo_cnt;
    logic              r_err_checksum, r_err_length, r_err_timeout, r_err_overrun;

    logic              w_timed, w_timeout, w_byte, w_wr_en, w_xfer;
    logic              w_wr_last, w_rd_last, w_cksum_ok, w_len_bad;
    logic [15:0]       w_len_rx;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [7:0]        w_rd_data;

    assign w_timed    = r_state inside {ST_HDR2, ST_CMD, ST_LEN_H, ST_LEN_L, ST_PAYLOAD, ST_CKSUM};
    assign w_timeout  = w_timed && (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
    // A byte landing on the expiry cycle is discarded along with the frame.
    assign w_byte     = usb_data_valid_in && !w_timeout;
    assign w_len_rx   = {r_len_hi, usb_data_in};
    assign w_len_bad  = w_len_rx > 16'(MAX_PAYLOAD);
    assign w_cksum_ok = usb_data_in == r_sum;
    assign w_wr_last  = {{(16-ADDR_W){1'b0}}, r_wr_idx} == r_len_work - 16'd1;
    assign w_rd_last  = {{(16-ADDR_W){1'b0}}, r_rd_idx} == r_cmd_len - 16'd1;
    assign w_xfer     = (r_state == ST_DRAIN) && cmd_data_ready;
    assign w_wr_en    = (r_state == ST_PAYLOAD) && w_byte;
    // Prefetch the next address on a transfer so sustained ready has no bubbles.
    assign w_rd_addr  = w_xfer ? r_rd_idx + ADDR_W'(1) : r_rd_idx;

    frame_payload_ram #(.ADDR_W(ADDR_W)) u_payload_ram (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_idx),
        .i_wr_data (usb_data_in),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (w_timeout) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:     if (usb_data_valid_in && usb_data_in == FRAME_HDR0) w_state_next = ST_HDR2;
                ST_HDR2:     if (usb_data_valid_in) begin
                                 if (usb_data_in == FRAME_HDR1)      w_state_next = ST_CMD;
                                 else if (usb_data_in != FRAME_HDR0) w_state_next = ST_IDLE;
                             end
                ST_CMD:      if (usb_data_valid_in) w_state_next = ST_LEN_H;
                ST_LEN_H:    if (usb_data_valid_in) w_state_next = ST_LEN_L;
                ST_LEN_L:    if (usb_data_valid_in) begin
                                 if (w_len_bad)              w_state_next = ST_IDLE;
                                 else if (w_len_rx == 16'd0) w_state_next = ST_CKSUM;
                                 else                        w_state_next = ST_PAYLOAD;
                             end
                ST_PAYLOAD:  if (usb_data_valid_in && w_wr_last) w_state_next = ST_CKSUM;
                ST_CKSUM:    if (usb_data_valid_in) w_state_next = w_cksum_ok ? ST_ANNOUNCE : ST_IDLE;
                ST_ANNOUNCE: w_state_next = (r_cmd_len == 16'd0) ? ST_DONE : ST_DRAIN;
                ST_DRAIN:    if (w_xfer && w_rd_last) w_state_next = ST_DONE;
                ST_DONE:     w_state_next = ST_IDLE;
                default:     w_state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        cmd_start      = r_state == ST_ANNOUNCE;
        cmd_data_valid = r_state == ST_DRAIN;
        cmd_done       = r_state == ST_DONE;
        cmd_data       = cmd_data_valid ? w_rd_data : 8'h00;
        // Stay busy through an error pulse so busy falls the cycle after it.
        busy           = (r_state != ST_IDLE) || r_err_checksum || r_err_length || r_err_timeout;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd_work     <= '0;
            r_len_hi       <= '0;
            r_len_work     <= '0;
            r_sum          <= '0;
            r_cmd_code     <= '0;
            r_cmd_len      <= '0;
            r_wr_idx       <= '0;
            r_rd_idx       <= '0;
            r_tmo_cnt      <= '0;
            r_err_checksum <= 1'b0;
            r_err_length   <= 1'b0;
            r_err_timeout  <= 1'b0;
            r_err_overrun  <= 1'b0;
        end else begin
            r_err_checksum <= 1'b0;
            r_err_length   <= 1'b0;
            r_err_timeout  <= w_timeout;
            r_err_overrun  <= usb_data_valid_in &&
                              (r_state inside {ST_ANNOUNCE, ST_DRAIN, ST_DONE});
            r_tmo_cnt      <= (!w_timed || usb_data_valid_in || w_timeout) ? '0 : r_tmo_cnt + TMO_W'(1);

            if (r_state == ST_DRAIN) begin
                if (w_xfer) r_rd_idx <= r_rd_idx + ADDR_W'(1);
            end else begin
                r_rd_idx <= '0;
            end

            if (w_byte) begin
                case (r_state)
                    ST_CMD: begin
                        r_cmd_work <= usb_data_in;
                        r_sum      <= usb_data_in;
                    end
                    ST_LEN_H: begin
                        r_len_hi <= usb_data_in;
                        r_sum    <= r_sum + usb_data_in;
                    end
                    ST_LEN_L: begin
                        r_len_work   <= w_len_rx;
                        r_sum        <= r_sum + usb_data_in;
                        r_wr_idx     <= '0;
                        r_err_length <= w_len_bad;
                    end
                    ST_PAYLOAD: begin
                        r_sum    <= r_sum + usb_data_in;
                        r_wr_idx <= r_wr_idx + ADDR_W'(1);
                    end
                    ST_CKSUM: begin
                        if (w_cksum_ok) begin
                            r_cmd_code <= r_cmd_work;
                            r_cmd_len  <= r_len_work;
                        end else begin
                            r_err_checksum <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign cmd_code     = r_cmd_code;
    assign cmd_len      = r_cmd_len;
    assign err_checksum = r_err_checksum;
    assign err_length   = r_err_length;
    assign err_timeout  = r_err_timeout;
    assign err_overrun  = r_err_overrun;

endmodule

// File: tb/tb_usb_cmd_frame_parser.sv
// Directed bench for usb_cmd_frame_parser: a vector table of whole frames plus
// hand-written sequences for max length, timeout, overrun and mid-frame reset.
module tb_usb_cmd_frame_parser;
    import usb_cmd_pkg::*;

    localparam int TMO = 1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  usb_data_in = 8'h00;
    logic        usb_data_valid_in = 1'b0;
    logic        cmd_data_ready = 1'b0;
    logic        cmd_start, cmd_data_valid, cmd_done, busy;
    logic [7:0]  cmd_code, cmd_data;
    logic [15:0] cmd_len;
    logic        err_checksum, err_length, err_timeout, err_overrun;

    always #5 clk = ~clk;

    usb_cmd_frame_parser #(.MAX_PAYLOAD(128), .TIMEOUT_CYCLES(TMO), .ADDR_W(7)) dut (
        .clk(clk), .rst(rst), .usb_data_in(usb_data_in), .usb_data_valid_in(usb_data_valid_in),
        .cmd_start(cmd_start), .cmd_code(cmd_code), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .cmd_data_valid(cmd_data_valid), .cmd_data_ready(cmd_data_ready), .cmd_done(cmd_done),
        .busy(busy), .err_checksum(err_checksum), .err_length(err_length),
        .err_timeout(err_timeout), .err_overrun(err_overrun)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_total = 0;
    int n_bad   = 0;

    function automatic void check(string nm, logic [31:0] got, logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
        end
    endfunction

    // Ready pattern: 0 = always ready, 1 = 1,0,0 repeating, 2 = held low.
    int rmode = 0;
    int rcnt  = 0;
    always @(posedge clk) begin
        #1;
        case (rmode)
            0: cmd_data_ready = 1'b1;
            1: begin cmd_data_ready = (rcnt % 3 == 0); rcnt++; end
            default: cmd_data_ready = 1'b0;
        endcase
    end

    // Monitor samples on the falling edge, well away from the active edge.
    int          start_cnt = 0, done_cnt = 0, ck_cnt = 0, le_cnt = 0, to_cnt = 0, ov_cnt = 0;
    int          start_cyc = 0, done_cyc = 0, err_cyc = 0;
    logic [7:0]  st_code;
    logic [15:0] st_len;
    logic [7:0]  data_q[$];
    int          beat_q[$];
    bit          prev_stall = 1'b0;
    logic [7:0]  prev_data;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (cmd_start) begin start_cnt++; st_code = cmd_code; st_len = cmd_len; start_cyc = cyc; end
            if (cmd_data_valid && cmd_data_ready) begin data_q.push_back(cmd_data); beat_q.push_back(cyc); end
            if (cmd_done) begin done_cnt++; done_cyc = cyc; end
            if (err_checksum) begin ck_cnt++; err_cyc = cyc; end
            if (err_length)   begin le_cnt++; err_cyc = cyc; end
            if (err_timeout)  begin to_cnt++; err_cyc = cyc; end
            if (err_overrun)  ov_cnt++;
            if (prev_stall) begin
                check("stall_valid_held", cmd_data_valid, 1);
                check("stall_data_stable", cmd_data, prev_data);
            end
            prev_stall = cmd_data_valid && !cmd_data_ready;
            prev_data  = cmd_data;
        end
    end

    logic [7:0] tx_q[$];
    int         last_cyc = 0;

    task automatic send_tx();
        for (int i = 0; i < tx_q.size(); i++) begin
            @(posedge clk); #1;
            usb_data_in       = tx_q[i];
            usb_data_valid_in = 1'b1;
            last_cyc          = cyc;
        end
        @(posedge clk); #1;
        usb_data_valid_in = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int k = 0;
        while (busy && k < 3000) begin @(posedge clk); #1; k++; end
        check({nm, "_idle_reached"}, (k < 3000), 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, "_flags"}, {cmd_start, cmd_data_valid, cmd_done, busy,
                               err_checksum, err_length, err_timeout, err_overrun}, 0);
        check({nm, "_code_len"}, {cmd_code, cmd_len}, 0);
        check({nm, "_data"}, cmd_data, 0);
    endtask

    typedef struct packed {
        int           nb;
        logic [127:0] bytes;     // first byte sent is the most significant used byte
        int           rmode;
        int           exp_start;
        logic [7:0]   code;
        logic [15:0]  len;
        int           nd;
        logic [63:0]  data;      // first payload byte is the most significant used byte
        int           exp_ck;
        int           exp_le;
    } vec_t;

    vec_t vt[7];
    vec_t v;
    int   b_st, b_dn, b_ck, b_le, b_to, b_ov, b_dq, k;
    logic [7:0] exp128[128];
    logic [7:0] sum;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d expected finish earlier", cyc);
        $fatal(1);
    end

    initial begin
        vt[0] = '{nb:8,  bytes:128'hAA55040002500157,         rmode:0, exp_start:1, code:8'h04, len:16'd2,
                  nd:2, data:64'h5001,         exp_ck:0, exp_le:0};
        vt[1] = '{nb:12, bytes:128'hAA55050006003CDEADBEEF7F, rmode:1, exp_start:1, code:8'h05, len:16'd6,
                  nd:6, data:64'h003CDEADBEEF, exp_ck:0, exp_le:0};
        vt[2] = '{nb:12, bytes:128'hAA55050006003CDEADBEEF80, rmode:0, exp_start:0, code:8'h00, len:16'd0,
                  nd:0, data:64'h0,            exp_ck:1, exp_le:0};
        vt[3] = '{nb:8,  bytes:128'hAA55040002500157,         rmode:0, exp_start:1, code:8'h04, len:16'd2,
                  nd:2, data:64'h5001,         exp_ck:0, exp_le:0};
        vt[4] = '{nb:5,  bytes:128'hAA55060081,               rmode:0, exp_start:0, code:8'h00, len:16'd0,
                  nd:0, data:64'h0,            exp_ck:0, exp_le:1};
        vt[5] = '{nb:6,  bytes:128'h040002500157,             rmode:0, exp_start:0, code:8'h00, len:16'd0,
                  nd:0, data:64'h0,            exp_ck:0, exp_le:0};
        vt[6] = '{nb:7,  bytes:128'hAAAA5513000013,           rmode:0, exp_start:1, code:8'h13, len:16'd0,
                  nd:0, data:64'h0,            exp_ck:0, exp_le:0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        for (int t = 0; t < 7; t++) begin
            v = vt[t];
            rmode = v.rmode; rcnt = 0;
            b_st = start_cnt; b_dn = done_cnt; b_ck = ck_cnt; b_le = le_cnt;
            b_to = to_cnt; b_ov = ov_cnt; b_dq = data_q.size();
            tx_q.delete();
            for (int i = 0; i < v.nb; i++) tx_q.push_back(v.bytes[(v.nb-1-i)*8 +: 8]);
            send_tx();
            wait_idle($sformatf("v%0d", t));
            check($sformatf("v%0d_busy_low", t), busy, 0);
            check($sformatf("v%0d_starts", t), start_cnt - b_st, v.exp_start);
            check($sformatf("v%0d_dones", t), done_cnt - b_dn, v.exp_start);
            check($sformatf("v%0d_err_checksum", t), ck_cnt - b_ck, v.exp_ck);
            check($sformatf("v%0d_err_length", t), le_cnt - b_le, v.exp_le);
            check($sformatf("v%0d_err_timeout", t), to_cnt - b_to, 0);
            check($sformatf("v%0d_err_overrun", t), ov_cnt - b_ov, 0);
            check($sformatf("v%0d_beats", t), data_q.size() - b_dq, v.nd);
            if (v.exp_start != 0) begin
                check($sformatf("v%0d_code", t), st_code, v.code);
                check($sformatf("v%0d_len", t), st_len, v.len);
                check($sformatf("v%0d_start_latency", t), start_cyc, last_cyc + 1);
                if (v.nd == 0) check($sformatf("v%0d_done_cycle", t), done_cyc, start_cyc + 1);
                else if (beat_q.size() > 0)
                    check($sformatf("v%0d_done_cycle", t), done_cyc, beat_q[beat_q.size()-1] + 1);
            end
            for (int d = 0; d < v.nd && b_dq + d < data_q.size(); d++) begin
                check($sformatf("v%0d_data%0d", t, d), data_q[b_dq+d], v.data[(v.nd-1-d)*8 +: 8]);
                if (v.rmode == 0)
                    check($sformatf("v%0d_beat%0d_cycle", t, d), beat_q[b_dq+d], start_cyc + 1 + d);
            end
            if (v.exp_ck != 0 || v.exp_le != 0)
                check($sformatf("v%0d_err_cycle", t), err_cyc, last_cyc + 1);
            $display("vec %0d: sent=%0d starts=%0d beats=%0d ck=%0d le=%0d", t, v.nb,
                     start_cnt - b_st, data_q.size() - b_dq, ck_cnt - b_ck, le_cnt - b_le);
        end

        // Maximum-length payload (128 bytes) is accepted and streamed without bubbles
        rmode = 0;
        b_st = start_cnt; b_le = le_cnt; b_dq = data_q.size();
        tx_q.delete();
        tx_q.push_back(8'hAA); tx_q.push_back(8'h55); tx_q.push_back(CMD_I2C_WRITE);
        tx_q.push_back(8'h00); tx_q.push_back(8'h80);
        sum = 8'h05 + 8'h00 + 8'h80;
        for (int i = 0; i < 128; i++) begin
            exp128[i] = 8'(i) ^ 8'h5A;
            tx_q.push_back(exp128[i]);
            sum = sum + exp128[i];
        end
        tx_q.push_back(sum);
        send_tx();
        wait_idle("max");
        check("max_starts", start_cnt - b_st, 1);
        check("max_err_length", le_cnt - b_le, 0);
        check("max_len", st_len, 16'd128);
        check("max_beats", data_q.size() - b_dq, 128);
        for (int d = 0; d < 128 && b_dq + d < data_q.size(); d++) begin
            check($sformatf("max_data%0d", d), data_q[b_dq+d], exp128[d]);
            check($sformatf("max_beat%0d_cycle", d), beat_q[b_dq+d], start_cyc + 1 + d);
        end
        $display("max frame: beats=%0d", data_q.size() - b_dq);

        // Inter-byte timeout on a partial header
        b_st = start_cnt; b_to = to_cnt;
        tx_q.delete();
        tx_q.push_back(8'hAA); tx_q.push_back(8'h55); tx_q.push_back(8'h05);
        tx_q.push_back(8'h00); tx_q.push_back(8'h04);
        send_tx();
        k = 0;
        while (to_cnt == b_to && k < TMO + 100) begin @(posedge clk); #1; k++; end
        check("tmo_pulses", to_cnt - b_to, 1);
        check("tmo_cycle", err_cyc, last_cyc + 1 + TMO);
        repeat (2) @(posedge clk);
        #1;
        check("tmo_busy_low", busy, 0);
        check("tmo_no_start", start_cnt - b_st, 0);
        $display("timeout: pulses=%0d at +%0d", to_cnt - b_to, err_cyc - last_cyc);

        // A byte on the expiry cycle is dropped: 55 must not advance HDR2
        b_st = start_cnt; b_to = to_cnt;
        tx_q.delete(); tx_q.push_back(8'hAA);
        send_tx();
        k = last_cyc;
        while (cyc < k + TMO) begin @(posedge clk); #1; end
        usb_data_in = 8'h55; usb_data_valid_in = 1'b1;
        tx_q.delete();
        tx_q.push_back(8'h05); tx_q.push_back(8'h00); tx_q.push_back(8'h00); tx_q.push_back(8'h05);
        send_tx();
        wait_idle("tmo_race");
        check("tmo_race_pulses", to_cnt - b_to, 1);
        check("tmo_race_cycle", err_cyc, k + 1 + TMO);
        check("tmo_race_no_start", start_cnt - b_st, 0);
        $display("timeout race: pulses=%0d starts=%0d", to_cnt - b_to, start_cnt - b_st);

        // Overrun: bytes arriving while the handler stalls the drain
        rmode = 2;
        b_st = start_cnt; b_dn = done_cnt; b_ov = ov_cnt; b_ck = ck_cnt; b_dq = data_q.size();
        tx_q.delete();
        for (int i = 0; i < 12; i++) tx_q.push_back(vt[1].bytes[(11-i)*8 +: 8]);
        send_tx();
        k = 0;
        while (start_cnt == b_st && k < 50) begin @(posedge clk); #1; k++; end
        check("ovr_start_seen", start_cnt - b_st, 1);
        tx_q.delete(); tx_q.push_back(8'hAA); tx_q.push_back(8'h55); tx_q.push_back(8'h04);
        send_tx();
        repeat (2) @(posedge clk);
        #1;
        check("ovr_pulses", ov_cnt - b_ov, 3);
        check("ovr_still_valid", cmd_data_valid, 1);
        rmode = 0;
        wait_idle("ovr");
        check("ovr_starts", start_cnt - b_st, 1);
        check("ovr_dones", done_cnt - b_dn, 1);
        check("ovr_err_checksum", ck_cnt - b_ck, 0);
        check("ovr_beats", data_q.size() - b_dq, 6);
        for (int d = 0; d < 6 && b_dq + d < data_q.size(); d++)
            check($sformatf("ovr_data%0d", d), data_q[b_dq+d], vt[1].data[(5-d)*8 +: 8]);
        $display("overrun: pulses=%0d beats=%0d", ov_cnt - b_ov, data_q.size() - b_dq);

        // Reset in the middle of a payload, then a clean frame
        tx_q.delete();
        for (int i = 0; i < 7; i++) tx_q.push_back(vt[1].bytes[(11-i)*8 +: 8]);
        send_tx();
        check("rst_busy_before", busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check_all_zero("midrst");
        rst = 1'b0;
        b_st = start_cnt; b_dn = done_cnt; b_dq = data_q.size();
        tx_q.delete();
        for (int i = 0; i < 8; i++) tx_q.push_back(vt[0].bytes[(7-i)*8 +: 8]);
        send_tx();
        wait_idle("postrst");
        check("postrst_starts", start_cnt - b_st, 1);
        check("postrst_dones", done_cnt - b_dn, 1);
        check("postrst_code", st_code, CMD_I2C_CONFIG);
        check("postrst_beats", data_q.size() - b_dq, 2);
        for (int d = 0; d < 2 && b_dq + d < data_q.size(); d++)
            check($sformatf("postrst_data%0d", d), data_q[b_dq+d], vt[0].data[(1-d)*8 +: 8]);
        $display("reset recovery: starts=%0d beats=%0d", start_cnt - b_st, data_q.size() - b_dq);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
